// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter slice.
//   XLEN          : address width of the cache/memory bus.
//   TAG_W         : width of memory transaction tags (tag 0 = none/rejected).
//   BUS_COMMAND   : bus command encoding shared by caches and memory.
//   ARB_OWNER     : which cache owns an outstanding memory tag.
//   ARB_TAG_ENTRY : one entry of the tag ownership table {valid, owner}.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      ARB_ICACHE = 1'b0,
      ARB_DCACHE = 1'b1
   } ARB_OWNER;

   typedef struct packed {
      logic     valid;
      ARB_OWNER owner;
   } ARB_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every cache-side, memory-side and arbiter-side bus signal of the
// memory bus arbiter.
//   modport slave  : the arbiter (reads cache requests and memory replies,
//                    drives the granted command and the per-cache returns).
//   modport master : the surrounding caches and memory model (opposite side).
// Signals:
//   icache2arb_*  icache request (command/addr)
//   dcache2arb_*  dcache request (command/addr/store data)
//   mem2arb_*     memory accept tag, returning tag and data
//   arb2mem_*     granted command/addr/store data
//   arb2icache_*  icache accept tag/valid and routed return tag/data
//   arb2dcache_*  dcache accept tag/valid and routed return tag/data
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   BUS_COMMAND             icache2arb_command;
   logic [XLEN-1:0]        icache2arb_addr;
   BUS_COMMAND             dcache2arb_command;
   logic [XLEN-1:0]        dcache2arb_addr;
   logic [63:0]            dcache2arb_data;

   logic [TAG_W-1:0]       mem2arb_response;
   logic [TAG_W-1:0]       mem2arb_tag;
   logic [63:0]            mem2arb_data;

   BUS_COMMAND             arb2mem_command;
   logic [XLEN-1:0]        arb2mem_addr;
   logic [63:0]            arb2mem_data;

   logic [TAG_W-1:0]       arb2icache_response;
   logic                   arb2icache_response_valid;
   logic [TAG_W-1:0]       arb2icache_tag;
   logic [63:0]            arb2icache_data;

   logic [TAG_W-1:0]       arb2dcache_response;
   logic                   arb2dcache_response_valid;
   logic [TAG_W-1:0]       arb2dcache_tag;
   logic [63:0]            arb2dcache_data;

   modport slave (
      input  icache2arb_command, icache2arb_addr,
      input  dcache2arb_command, dcache2arb_addr, dcache2arb_data,
      input  mem2arb_response, mem2arb_tag, mem2arb_data,
      output arb2mem_command, arb2mem_addr, arb2mem_data,
      output arb2icache_response, arb2icache_response_valid,
      output arb2icache_tag, arb2icache_data,
      output arb2dcache_response, arb2dcache_response_valid,
      output arb2dcache_tag, arb2dcache_data
   );

   modport master (
      output icache2arb_command, icache2arb_addr,
      output dcache2arb_command, dcache2arb_addr, dcache2arb_data,
      output mem2arb_response, mem2arb_tag, mem2arb_data,
      input  arb2mem_command, arb2mem_addr, arb2mem_data,
      input  arb2icache_response, arb2icache_response_valid,
      input  arb2icache_tag, arb2icache_data,
      input  arb2dcache_response, arb2dcache_response_valid,
      input  arb2dcache_tag, arb2dcache_data
   );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// -----------------------------------------------------------------------------
// mem_arb_tag_table
// Ownership table for outstanding memory tags: one {valid, owner} entry per
// tag. A lookup of a valid, non-zero tag reports a hit with the owner and
// clears the entry; an allocation in the same cycle to the same tag overrides
// that clear, while the lookup still reports the previous owner.
// Ports:
//   clock, reset        : clock, synchronous active-high reset (clears table)
//   alloc_en_i          : write {1, alloc_owner_i} to entry alloc_tag_i
//   alloc_tag_i         : tag to allocate (never 0)
//   alloc_owner_i       : requester that owns the new tag
//   lookup_tag_i        : returning tag from memory (0 = none)
//   hit_o               : lookup_tag_i names a valid entry
//   hit_owner_o         : owner of that entry
// -----------------------------------------------------------------------------
module mem_arb_tag_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NUM_TAGS = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             alloc_en_i,
   input  logic [TAG_W-1:0] alloc_tag_i,
   input  ARB_OWNER         alloc_owner_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   output logic             hit_o,
   output ARB_OWNER         hit_owner_o
);

   ARB_TAG_ENTRY table_q [NUM_TAGS];
   ARB_TAG_ENTRY table_d [NUM_TAGS];

   always_comb begin
      hit_o       = 1'b0;
      hit_owner_o = ARB_ICACHE;
      for (int i = 0; i < NUM_TAGS; i++) begin
         table_d[i] = table_q[i];
      end

      // Returns during reset are dropped, so no hit is reported then.
      if (!reset && (lookup_tag_i != '0) && table_q[lookup_tag_i].valid) begin
         hit_o                 = 1'b1;
         hit_owner_o           = table_q[lookup_tag_i].owner;
         table_d[lookup_tag_i] = '{valid: 1'b0, owner: ARB_ICACHE};
      end

      // Written after the clear so a same-cycle reallocation keeps the entry.
      if (alloc_en_i && (alloc_tag_i != '0)) begin
         table_d[alloc_tag_i] = '{valid: 1'b1, owner: alloc_owner_i};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            table_q[i] <= '{valid: 1'b0, owner: ARB_ICACHE};
         end
      end else begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single memory bus between the icache and the dcache. One
// requester is granted per cycle; memory answers with an accept tag in the
// same cycle, which is forwarded to the granted cache only. The owner of each
// accepted load tag is recorded so returning data reaches that cache only.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : conflicts resolved round-robin (the requester
//                              not granted last time wins; last grant updates
//                              on accepted grants only).
//                  undefined : dcache has fixed priority; the icache is
//                              force-granted after STARVE_LIMIT refusals.
//   The starvation override is active in both builds.
//
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high; all outputs held at BUS_NONE/0
//   bus    : mem_bus_arbiter_if.slave (cache requests, memory replies,
//            granted command, per-cache accept tags and routed returns)
// Parameters:
//   NUM_TAGS     : tag ownership table size (tag 0 never allocated)
//   STARVE_LIMIT : consecutive icache refusals before a forced icache grant
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NUM_TAGS     = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   mem_bus_arbiter_if.slave  bus
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_q, starve_d;

   logic     i_req, d_req;
   logic     force_i;
   logic     grant_i, grant_d;
   logic     accepted;
   logic     alloc_en;
   ARB_OWNER alloc_owner;
   logic     hit;
   ARB_OWNER hit_owner;

`ifdef MEM_ARB_RR_EN
   ARB_OWNER last_q, last_d;
`endif

   // ---------------- grant selection ----------------
   always_comb begin
      // Requests are ignored while in reset so nothing is granted or allocated.
      i_req   = !reset && (bus.icache2arb_command != BUS_NONE);
      d_req   = !reset && (bus.dcache2arb_command != BUS_NONE);
      force_i = i_req && (starve_q == STARVE_MAX);
`ifdef MEM_ARB_RR_EN
      grant_i = i_req && (!d_req || force_i || (last_q == ARB_DCACHE));
`else
      grant_i = i_req && (!d_req || force_i);
`endif
      grant_d  = d_req && !grant_i;
      accepted = (bus.mem2arb_response != '0);
   end

   // ---------------- memory-side command and per-cache accept tags ----------------
   always_comb begin
      bus.arb2mem_command           = BUS_NONE;
      bus.arb2mem_addr              = '0;
      bus.arb2mem_data              = '0;
      bus.arb2icache_response       = '0;
      bus.arb2icache_response_valid = 1'b0;
      bus.arb2dcache_response       = '0;
      bus.arb2dcache_response_valid = 1'b0;
      alloc_en                      = 1'b0;
      alloc_owner                   = ARB_ICACHE;

      if (grant_i) begin
         bus.arb2mem_command           = bus.icache2arb_command;
         bus.arb2mem_addr              = bus.icache2arb_addr;
         bus.arb2icache_response       = bus.mem2arb_response;
         bus.arb2icache_response_valid = 1'b1;
         alloc_en    = accepted && (bus.icache2arb_command == BUS_LOAD);
         alloc_owner = ARB_ICACHE;
      end else if (grant_d) begin
         bus.arb2mem_command           = bus.dcache2arb_command;
         bus.arb2mem_addr              = bus.dcache2arb_addr;
         // Store data is only placed on the bus for a dcache store grant.
         if (bus.dcache2arb_command == BUS_STORE) begin
            bus.arb2mem_data = bus.dcache2arb_data;
         end
         bus.arb2dcache_response       = bus.mem2arb_response;
         bus.arb2dcache_response_valid = 1'b1;
         // Stores get no returning data, so their tags are never tracked.
         alloc_en    = accepted && (bus.dcache2arb_command == BUS_LOAD);
         alloc_owner = ARB_DCACHE;
      end
   end

   // ---------------- starvation counter / last grant next state ----------------
   always_comb begin
      starve_d = starve_q;
      if (!i_req || grant_i) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + SW'(1);
      end
   end

`ifdef MEM_ARB_RR_EN
   always_comb begin
      last_d = last_q;
      if (grant_i && accepted) begin
         last_d = ARB_ICACHE;
      end else if (grant_d && accepted) begin
         last_d = ARB_DCACHE;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_q   <= ARB_ICACHE;
`endif
      end else begin
         starve_q <= starve_d;
`ifdef MEM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   // ---------------- tag ownership table ----------------
   mem_arb_tag_table #(
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_table (
      .clock         (clock),
      .reset         (reset),
      .alloc_en_i    (alloc_en),
      .alloc_tag_i   (bus.mem2arb_response),
      .alloc_owner_i (alloc_owner),
      .lookup_tag_i  (bus.mem2arb_tag),
      .hit_o         (hit),
      .hit_owner_o   (hit_owner)
   );

   // ---------------- return routing ----------------
   always_comb begin
      bus.arb2icache_tag  = '0;
      bus.arb2icache_data = '0;
      bus.arb2dcache_tag  = '0;
      bus.arb2dcache_data = '0;
      if (hit) begin
         if (hit_owner == ARB_ICACHE) begin
            bus.arb2icache_tag  = bus.mem2arb_tag;
            bus.arb2icache_data = bus.mem2arb_data;
         end else begin
            bus.arb2dcache_tag  = bus.mem2arb_tag;
            bus.arb2dcache_data = bus.mem2arb_data;
         end
      end
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the instruction cache (prefetch/miss loads) and the data cache (loads and stores).
- Grants one requester per cycle and forwards its command, address and data to memory.
- Records which requester owns each outstanding 4-bit memory tag, and routes returning data back to that owner only.
- Sits between icache/dcache and the memory model; each cache sees a private, memory-like port.

Parameters:
- NUM_TAGS, 16, size of the tag ownership table (tag 0 means "no tag/rejected" and is never allocated).
- STARVE_LIMIT, 4, consecutive cycles the icache may be refused before it is force-granted.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- icache2arb_command  in  BUS_COMMAND  icache request (BUS_NONE or BUS_LOAD only).
- icache2arb_addr  in  XLEN  icache block address, 8-byte aligned.
- dcache2arb_command  in  BUS_COMMAND  dcache request (BUS_NONE, BUS_LOAD or BUS_STORE).
- dcache2arb_addr  in  XLEN  dcache address.
- dcache2arb_data  in  64  dcache store data.
- mem2arb_response  in  4  memory accept tag for this cycle's command; 0 = rejected.
- mem2arb_tag  in  4  tag of the returning data; 0 = none.
- mem2arb_data  in  64  returning data.
- arb2mem_command  out  BUS_COMMAND  granted command.
- arb2mem_addr  out  XLEN  granted address.
- arb2mem_data  out  64  store data (0 unless the dcache holds a store grant).
- arb2icache_response  out  4  icache accept tag.
- arb2icache_response_valid  out  1  the icache was granted this cycle.
- arb2icache_tag  out  4  returning tag routed to the icache.
- arb2icache_data  out  64  returning data routed to the icache.
- arb2dcache_response  out  4  dcache accept tag.
- arb2dcache_response_valid  out  1  the dcache was granted this cycle.
- arb2dcache_tag  out  4  returning tag routed to the dcache.
- arb2dcache_data  out  64  returning data routed to the dcache.

Behaviour:
- Grant is combinational from current requests plus registered state:
  - The memory answers within the same cycle, so the response is forwarded to the granted cache only.
  - The non-granted cache sees response 0 and response_valid 0, and retries.
- Default priority: dcache over icache, except when the force-icache condition below holds.
- Starvation counter (starve_cnt):
  - Increments each cycle the icache requests but is not granted, saturating at STARVE_LIMIT.
  - Clears whenever the icache is granted or its command is BUS_NONE.
  - When starve_cnt == STARVE_LIMIT and the icache requests, the icache is granted even if the dcache also requests.
- Ownership table: NUM_TAGS entries, each {valid, owner}, with owner 0 = icache and 1 = dcache.
  - On a granted BUS_LOAD with mem2arb_response != 0: entry[response] <= {1, granted requester}.
  - BUS_STORE accepts allocate nothing.
- Return routing:
  - When mem2arb_tag != 0 and entry[tag].valid, drive that tag and data to the owner's tag/data ports. The other cache sees tag 0 and data 0.
  - The entry is then cleared.
  - A returning tag with no valid entry is dropped; both caches see tag 0.
- Simultaneous events:
  - Return of tag T and a new allocation of T in the same cycle: the routing uses the old owner, and the allocation wins the table write.
  - Both caches idle: arb2mem_command = BUS_NONE, addr 0, data 0.
- Rejected grant (response 0): the table is unchanged, and starve_cnt updates as for a refusal only if the icache was not the granted requester.
- Reset: table cleared, starve_cnt 0, last-grant register 0. Outputs during reset: command BUS_NONE, all responses, tags and data 0, valids 0. Returns arriving during reset are dropped.
- Misprediction flushes are handled by the icache. The arbiter still routes stale icache returns to the icache.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin replaces fixed priority. On a conflict, the requester not granted last time wins. The last-grant register updates only on accepted grants. The starvation counter is still present but becomes redundant.
- Undefined: fixed dcache priority with the starvation override, as described above.

Decomposition:
- BUS_COMMAND and XLEN come from the existing shared sys_defs package.
- Add to that package: ARB_OWNER enum {ARB_ICACHE, ARB_DCACHE}, and typedef ARB_TAG_ENTRY {valid, owner}.
- One natural sub-module: mem_arb_tag_table (allocate port, lookup/clear port, reset).

Test Plan:
1. Icache LOAD 0x100 alone, mem response 3; later tag 3, data 0xAAAA -> icache gets response 3, response_valid 1, then tag 3 / data 0xAAAA; dcache sees tag 0.
2. Both request in the same cycle, response 5 -> dcache granted and gets 5; icache sees response 0; later tag 5 goes to the dcache only.
3. Dcache requests every cycle with the icache also requesting -> icache force-granted on the 5th cycle (after 4 refusals); starve_cnt returns to 0.
4. Dcache STORE 0x200, data 0x1234, response 7 -> arb2mem_data 0x1234, no table entry; a later stray tag 7 is dropped (both caches see tag 0).
5. Tag 2 returns (icache owner) in the same cycle the dcache load is accepted with response 2 -> icache receives the data; the table now shows dcache owns tag 2.
6. Reset asserted with 3 outstanding tags -> table empty; returns for those tags are dropped; outputs BUS_NONE/0.
